// File: rtl/csr_pkg.sv
// Shared CSR address map, csr_op encoding and address decode for csr_unit.
package csr_pkg;

    localparam logic [11:0] CSR_TOHOST   = 12'h51E;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RW   = 2'b01;
    localparam logic [1:0] CSR_OP_RS   = 2'b10;
    localparam logic [1:0] CSR_OP_RC   = 2'b11;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TOHOST,
        SEL_CYCLE,
        SEL_CYCLEH,
        SEL_INSTRET,
        SEL_INSTRETH
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [11:0] addr);
        case (addr)
            CSR_TOHOST:   return SEL_TOHOST;
            CSR_CYCLE:    return SEL_CYCLE;
            CSR_CYCLEH:   return SEL_CYCLEH;
            CSR_INSTRET:  return SEL_INSTRET;
            CSR_INSTRETH: return SEL_INSTRETH;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable; the full-width add keeps
// the carry into the upper word inside a single edge.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_en,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_unit.sv
// Machine-level CSR block: tohost read/write, cycle/instret counters, sticky done.
// Counter flops exist only when CSR_COUNTERS_EN is defined; otherwise counters read 0.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wmask_en,
    input  logic        retire,
    input  logic        stall,
    output logic [31:0] csr_rdata,
    output logic        illegal,
    output logic [31:0] tohost,
    output logic        done
);

    csr_sel_e    w_sel;
    logic        w_is_counter;
    logic        w_write_req;
    logic        w_tohost_we;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [63:0] w_cycle;
    logic [63:0] w_instret;
    logic [31:0] r_tohost;
    logic        r_done;

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_cycle (
        .clk      (clk),
        .rst      (rst),
        .i_inc_en (1'b1),
        .o_count  (w_cycle)
    );

    csr_counter64 u_instret (
        .clk      (clk),
        .rst      (rst),
        .i_inc_en (retire && !stall),
        .o_count  (w_instret)
    );
`else
    logic w_unused_retire;
    assign w_unused_retire = retire;
    assign w_cycle         = '0;
    assign w_instret       = '0;
`endif

    assign w_sel        = csr_decode(csr_addr);
    assign w_is_counter = (w_sel != SEL_NONE) && (w_sel != SEL_TOHOST);
    assign w_write_req  = (csr_op == CSR_OP_RW) ||
                          (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && csr_wmask_en);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_old = '0;
        case (w_sel)
            SEL_TOHOST:   w_old = r_tohost;
            SEL_CYCLE:    w_old = w_cycle[31:0];
            SEL_CYCLEH:   w_old = w_cycle[63:32];
            SEL_INSTRET:  w_old = w_instret[31:0];
            SEL_INSTRETH: w_old = w_instret[63:32];
            default:      w_old = '0;
        endcase
    end

    always_comb begin
        w_new = r_tohost;
        case (csr_op)
            CSR_OP_RW: w_new = csr_wdata;
            CSR_OP_RS: w_new = r_tohost | csr_wdata;
            CSR_OP_RC: w_new = r_tohost & ~csr_wdata;
            default:   w_new = r_tohost;
        endcase
    end

    // Fault reporting ignores stall; the pipeline discards it while frozen.
    assign csr_rdata   = csr_en ? w_old : '0;
    assign illegal     = csr_en && ((w_sel == SEL_NONE) || (w_is_counter && w_write_req));
    assign w_tohost_we = csr_en && !stall && (w_sel == SEL_TOHOST) && w_write_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tohost <= RESET_TOHOST;
            r_done   <= 1'b0;
        end else if (w_tohost_we) begin
            r_tohost <= w_new;
            r_done   <= r_done || (w_new != 32'd0);
        end
    end

    assign tohost = r_tohost;
    assign done   = r_done;

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-level CSR block for the pipelined RV32I core, in the writeback stage. Executes CSRRW/CSRRS/CSRRC and immediate forms against the `tohost` register (0x51E), which the simulation benches poll for pass/fail. Provides 64-bit cycle and instret counters. Exports a sticky `done` flag once software reports a result.

## Interface

Parameters:
- `RESET_TOHOST`, default 32'h0: reset value of `tohost`.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `csr_en`  in  1: a CSR instruction is in writeback this cycle.
- `csr_op`  in  2: 01 = RW, 10 = RS, 11 = RC, 00 = no-op/read-only.
- `csr_addr`  in  12: CSR address.
- `csr_wdata`  in  32: rs1 value, or zero-extended uimm.
- `csr_wmask_en`  in  1: 0 when rs1/uimm is x0/0 for RS/RC, which suppresses the write.
- `retire`  in  1: one instruction retires this cycle.
- `stall`  in  1: writeback is frozen; CSR side effects are blocked.
- `csr_rdata`  out  32: old CSR value (combinational); goes to rd.
- `illegal`  out  1: combinational; access faulted this cycle.
- `tohost`  out  32: current `tohost` register.
- `done`  out  1: sticky; set after the first nonzero `tohost` write.

## Operation

Address map:
- 0x51E `tohost`: read/write.
- 0xC00 / 0xC80 `cycle` / `cycleh`: read-only.
- 0xC02 / 0xC82 `instret` / `instreth`: read-only.

Effective access is `csr_en && !stall`.

Write value by op:
- RW: `wdata`.
- RS: `old | wdata`.
- RC: `old & ~wdata`.

Write suppression:
- RS or RC with `csr_wmask_en` = 0 performs no write.
- Op 00 performs no write.

Fault rules:
- Unknown address: `illegal` = 1 and `csr_rdata` = 0.
- Write attempt to a read-only counter: `illegal` = 1, no state change, `csr_rdata` still returns the counter value.
- A faulting access never modifies `tohost`.

Counters:
- `cycle` increments every cycle while not in reset, including during stall.
- `instret` increments when `retire && !stall`.
- Both are 64-bit and wrap from 2^64−1 to 0.
- Carry into the upper word is atomic within the clock edge.

`done` is set the cycle after an effective `tohost` write with a nonzero result. Once set it stays high until `rst`. Later writes update `tohost` but do not clear `done`.

## Timing

Reset values (asynchronous, on `rst` assertion):
- `tohost` = `RESET_TOHOST`.
- `cycle` = 0, `instret` = 0, `done` = 0.
- `csr_rdata` = 0 and `illegal` = 0 while `csr_en` = 0.

Latency and visibility:
- Reads are combinational and return the pre-write value in the same cycle.
- A write at edge N is visible on `csr_rdata` and `tohost` from cycle N+1.
- `done` rises together with `tohost` becoming nonzero, i.e. one edge after the write cycle.

Counter reads:
- A counter read in cycle N returns the count before edge N.
- `instret` does not include the reading instruction itself.

Boundary conditions:
- `retire` and an `instret` read in the same cycle: read returns the old value.
- `stall` high: no write, no `instret` increment, `illegal` still reported combinationally. The pipeline must ignore `illegal` while stalled.
- `rst` mid-operation: all state clears immediately, and a pending write is lost.
- The first cycle after `rst` deasserts, `cycle` counts 0→1.

## Configuration

- `CSR_COUNTERS_EN` defined: `cycle`/`instret` logic is present as described above.
- Not defined:
  - The counter addresses still decode as legal read-only CSRs.
  - Reads return 0.
  - Write attempts still raise `illegal`.
  - No counter flops are synthesized.
  - `tohost` and `done` are unaffected.

## Structure

- `csr_pkg` holds:
  - Address constants `CSR_TOHOST`, `CSR_CYCLE`, `CSR_CYCLEH`, `CSR_INSTRET`, `CSR_INSTRETH`.
  - The `csr_op` encoding constants `CSR_OP_NONE`/`RW`/`RS`/`RC`.
- One sub-module, `csr_counter64`: 64-bit counter with an increment enable and async reset. It is instantiated twice, under `CSR_COUNTERS_EN`.
- Decode, op logic, `tohost` and `done` are in `csr_unit`.

## Test plan

1. Reset, then a RW to 0x51E with wdata 0x1 → `tohost` = 1 and `done` = 1 on the next cycle; `csr_rdata` during the write = 0.
2. `tohost` = 0x00F0, RS with 0x000F → 0x00FF; then RC with 0x00F0 → 0x000F; RS with `csr_wmask_en` = 0 → unchanged, `csr_rdata` = 0x000F.
3. Write 0x5 to 0xC00 → `illegal` = 1 and counter unchanged; read 0x7C0 → `illegal` = 1, `csr_rdata` = 0.
4. 10 cycles after reset with `retire` high for 6 of them → reads `cycle` = 10 and `instret` = 6, both upper words 0.
5. Force `cycle` to 0x0000_0000_FFFF_FFFF via hierarchical deposit, one edge → `cycleh` = 1, `cycle` = 0.
6. RW 0x3 to `tohost` with `stall` = 1 → no change, `done` stays 0; assert `rst` mid-run after `done` = 1 → `done`, `tohost` and counters all 0 immediately.
